// File: rtl/instr_dispatch_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_dispatch_fsm_pkg
// Purpose : Shared definitions for the instruction fetch/dispatch controller:
//           opcode values, start-vector bit indices, FSM state encoding and
//           small opcode-decode helpers.
// Ports   : (package, none)
// Config  : INSTR_WATCHDOG_EN is consumed by instr_dispatch_fsm, not here.
// Revision: 1.0 - initial release
// ============================================================================
package instr_dispatch_fsm_pkg;

  // Opcode field values (ir[15:12])
  localparam logic [3:0] c_OP_NOP   = 4'h0;
  localparam logic [3:0] c_OP_ALU   = 4'h1;
  localparam logic [3:0] c_OP_ALUI  = 4'h2;
  localparam logic [3:0] c_OP_LOAD  = 4'h3;
  localparam logic [3:0] c_OP_STORE = 4'h4;
  localparam logic [3:0] c_OP_JUMP  = 4'h8;
  localparam logic [3:0] c_OP_HALT  = 4'hF;

  // One-hot start vector bit positions
  localparam int c_START_W     = 4;
  localparam int c_START_ALU   = 0;
  localparam int c_START_LOAD  = 1;
  localparam int c_START_STORE = 2;
  localparam int c_START_JUMP  = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_MEMWAIT = 3'd2,
    ST_DECODE  = 3'd3,
    ST_EXEC    = 3'd4,
    ST_ADVANCE = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OPK_NOP     = 2'd0,
    OPK_EXEC    = 2'd1,
    OPK_HALT    = 2'd2,
    OPK_ILLEGAL = 2'd3
  } op_kind_t;

  // Coarse classification used by DECODE to pick the next state.
  function automatic op_kind_t op_kind(input logic [3:0] op);
    op_kind_t k;
    case (op)
      c_OP_NOP:   k = OPK_NOP;
      c_OP_ALU,
      c_OP_ALUI,
      c_OP_LOAD,
      c_OP_STORE,
      c_OP_JUMP:  k = OPK_EXEC;
      c_OP_HALT:  k = OPK_HALT;
      default:    k = OPK_ILLEGAL;
    endcase
    return k;
  endfunction

  // One-hot start vector for an executable opcode; zero for anything else.
  function automatic logic [c_START_W-1:0] start_vec(input logic [3:0] op);
    logic [c_START_W-1:0] v;
    v = '0;
    case (op)
      c_OP_ALU,
      c_OP_ALUI:  v[c_START_ALU]   = 1'b1;
      c_OP_LOAD:  v[c_START_LOAD]  = 1'b1;
      c_OP_STORE: v[c_START_STORE] = 1'b1;
      c_OP_JUMP:  v[c_START_JUMP]  = 1'b1;
      default:    v = '0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_dispatch_fsm_pc_reg.sv
`default_nettype none
// ============================================================================
// Module  : instr_dispatch_fsm_pc_reg
// Purpose : Program counter with absolute load and +1 increment. Load has
//           priority over increment; increment wraps silently at 2^ADDR_W.
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           inc_i           - add one to PC
//           load_i          - replace PC with load_addr_i (wins over inc_i)
//           load_addr_i     - load target
//           pc_o            - current PC
// Revision: 1.0 - initial release
// ============================================================================
module instr_dispatch_fsm_pc_reg #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= ADDR_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/instr_dispatch_fsm.sv
`default_nettype none
// ============================================================================
// Module  : instr_dispatch_fsm
// Purpose : Instruction fetch/dispatch controller. Fetches 16-bit words from
//           a synchronous program ROM, presents the instruction on ir_out_o,
//           raises a one-hot class start and waits for done_i from the
//           execution FSM. ir_out_o returns to zero between instructions so
//           the execution FSMs fall back to idle. Owns the PC.
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           run_i           - 1 = run, 0 = stop at next instruction boundary
//           mem_addr_o      - ROM address (= PC)
//           mem_rd_o        - ROM read strobe, data valid the next cycle
//           mem_data_i      - ROM read data
//           ir_out_o        - instruction word to execution FSMs
//           start_o         - one-hot class [0]ALU [1]LOAD [2]STORE [3]JUMP
//           pc_inc_i        - PC += 1 request (EXEC only)
//           pc_load_i       - PC <= jump_addr_i request (EXEC only, wins)
//           jump_addr_i     - jump target
//           done_i          - execution completion (EXEC only)
//           halted_o        - in HALT
//           illegal_o       - sticky undefined-opcode / timeout flag
//           busy_o          - not IDLE and not HALT
// Config  : `define INSTR_WATCHDOG_EN adds an EXEC cycle counter; TIMEOUT
//           EXEC cycles without done_i sets illegal and forces ADVANCE.
// Revision: 1.0 - initial release
// ============================================================================
module instr_dispatch_fsm
  import instr_dispatch_fsm_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [15:0]       mem_data_i,
  output logic [15:0]       ir_out_o,
  output logic [3:0]        start_o,
  input  logic              pc_inc_i,
  input  logic              pc_load_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              done_i,
  output logic              halted_o,
  output logic              illegal_o,
  output logic              busy_o
);

  state_t            state_q;
  state_t            state_d;
  logic [15:0]       ir_q;
  logic [15:0]       ir_d;
  logic              touched_q;
  logic              touched_d;
  logic              illegal_q;
  logic              illegal_d;
  logic              w_pc_inc;
  logic              w_pc_load;
  logic              w_wd_expire;
  logic [ADDR_W-1:0] w_pc;

  // --------------------------------------------------------------------------
  // Program counter
  // --------------------------------------------------------------------------
  instr_dispatch_fsm_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (w_pc_inc),
    .load_i      (w_pc_load),
    .load_addr_i (jump_addr_i),
    .pc_o        (w_pc)
  );

  // --------------------------------------------------------------------------
  // Optional EXEC watchdog
  // --------------------------------------------------------------------------
`ifdef INSTR_WATCHDOG_EN
  localparam int c_WD_W = $clog2(TIMEOUT + 1);

  logic [c_WD_W-1:0] wd_cnt_q;
  logic [c_WD_W-1:0] wd_cnt_d;

  // Expires on the TIMEOUT-th EXEC cycle; a done_i in that same cycle wins.
  assign w_wd_expire = (state_q == ST_EXEC) && !done_i &&
                       (wd_cnt_q == c_WD_W'(TIMEOUT - 1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == ST_DECODE) begin
      wd_cnt_d = '0;
    end else if (state_q == ST_EXEC) begin
      wd_cnt_d = wd_cnt_q + c_WD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign w_wd_expire = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ir_q      <= 16'h0000;
      touched_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      touched_q <= touched_d;
      illegal_q <= illegal_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic and PC control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    touched_d = touched_q;
    illegal_d = illegal_q;
    w_pc_inc  = 1'b0;
    w_pc_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run_i) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_d = ST_MEMWAIT;
      end

      ST_MEMWAIT: begin
        ir_d    = mem_data_i;
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        touched_d = 1'b0;
        case (op_kind(ir_q[15:12]))
          OPK_NOP:     state_d = ST_ADVANCE;
          OPK_ILLEGAL: begin
            illegal_d = 1'b1;
            state_d   = ST_ADVANCE;
          end
          OPK_HALT:    state_d = ST_HALT;
          default:     state_d = ST_EXEC;
        endcase
      end

      ST_EXEC: begin
        // PC requests take effect immediately; remembering them stops
        // ADVANCE from stepping the PC a second time.
        w_pc_load = pc_load_i;
        w_pc_inc  = pc_inc_i;
        if (pc_inc_i || pc_load_i) begin
          touched_d = 1'b1;
        end
        if (done_i) begin
          state_d = ST_ADVANCE;
        end else if (w_wd_expire) begin
          illegal_d = 1'b1;
          state_d   = ST_ADVANCE;
        end
      end

      ST_ADVANCE: begin
        if (!touched_q) begin
          w_pc_inc = 1'b1;
        end
        state_d = run_i ? ST_FETCH : ST_IDLE;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from state; ir_out is zero outside DECODE/EXEC)
  // --------------------------------------------------------------------------
  always_comb begin
    mem_rd_o = 1'b0;
    ir_out_o = 16'h0000;
    start_o  = '0;
    if (state_q == ST_FETCH) begin
      mem_rd_o = 1'b1;
    end
    if ((state_q == ST_DECODE) || (state_q == ST_EXEC)) begin
      ir_out_o = ir_q;
    end
    if (state_q == ST_EXEC) begin
      start_o = start_vec(ir_q[15:12]);
    end
  end

  assign mem_addr_o = w_pc;
  assign halted_o   = (state_q == ST_HALT);
  assign illegal_o  = illegal_q;
  assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule
`default_nettype wire
